// File: rtl/dp_psum_pp_buffer_pkg.sv
// Shared constants and drain FSM encoding for the psum ping-pong buffer.
package dp_psum_pp_buffer_pkg;

  localparam int DP_COMMON_BRAM_DELAY = 2;

  typedef enum logic [1:0] {
    DP_PSUM_IDLE  = 2'd0,
    DP_PSUM_DRAIN = 2'd1,
    DP_PSUM_FLUSH = 2'd2
  } psum_state_e;

endpackage

// File: rtl/dp_psum_skid_fifo.sv
// Small synchronous FIFO that absorbs drain reads still in the RAM pipeline
// when the downstream stream stalls; reports free slots for read crediting.
module dp_psum_skid_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  localparam int FW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [FW-1:0]    free_slots
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [FW-1:0]    count;
  logic             pop;

  assign pop        = out_valid && out_ready;
  assign out_valid  = (count != '0);
  assign out_data   = out_valid ? mem[rd_ptr] : '0;
  assign free_slots = FW'(DEPTH) - count;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dp_psum_pp_buffer.sv
// Partial-sum ping-pong buffer: one bank serves the madd read-modify-write
// loop while the other is drained as a ready/valid stream.
//
// state | meaning
// IDLE  | no drain active, madd bank free
// DRAIN | issuing drain reads of the completed bank
// FLUSH | all reads issued, waiting for the last word to be accepted
module dp_psum_pp_buffer
  import dp_psum_pp_buffer_pkg::*;
#(
  parameter int COE_WIDTH         = 39,
  parameter int ADDR_WIDTH        = 9,
  parameter int LOG_NUM_BANK      = 3,
  parameter int NUM_POLY          = 3,
  parameter int COMMON_BRAM_DELAY = DP_COMMON_BRAM_DELAY,
  localparam int AW = ADDR_WIDTH + LOG_NUM_BANK,
  localparam int DW = COE_WIDTH * NUM_POLY * 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_madd_we,
  input  logic [AW-1:0] i_madd_wraddr,
  input  logic [DW-1:0] i_madd_data,
  input  logic [AW-1:0] i_madd_rdaddr,
  input  logic          i_first_pass,
  output logic [DW-1:0] o_madd_data,
  input  logic          i_swap,
  output logic          o_madd_ready,
  output logic          o_out_valid,
  output logic [DW-1:0] o_out_data,
  output logic          o_out_last,
  input  logic          i_out_ready,
  output logic          o_drain_done,
  output logic          o_err
);

  localparam int D     = COMMON_BRAM_DELAY;
  localparam int DEPTH = 2 ** AW;
  localparam int FDEP  = D + 1;
  localparam int FW    = $clog2(FDEP + 1);
  localparam int EW    = FW + 1;

  logic [DW-1:0] mem [2][DEPTH];

  psum_state_e   state, state_d;
  logic [AW-1:0] rd_cnt, rd_cnt_d;
  logic          wr_sel, wr_sel_d;
  logic          swap_pending, swap_pending_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          issue;

  logic [DW-1:0] rd_pipe [D];
  logic [D-1:0]  fp_pipe;
  logic [DW-1:0] dr_data [D];
  logic [D-1:0]  dr_vld;
  logic [D-1:0]  dr_last;

  logic [FW-1:0] free_slots;
  logic [FW-1:0] inflight;
  logic [DW:0]   fifo_out;
  logic          pop;
  logic          credit_ok;
  logic          last_accept;

  assign o_madd_ready = !swap_pending;
  assign o_madd_data  = fp_pipe[D-1] ? '0 : rd_pipe[D-1];
  assign o_out_last   = fifo_out[DW];
  assign o_out_data   = fifo_out[DW-1:0];
  assign o_drain_done = done_q;
  assign o_err        = err_q;
  assign pop          = o_out_valid && i_out_ready;
  assign last_accept  = pop && o_out_last;

  always_ff @(posedge clk) begin
    if (!rst && i_madd_we && o_madd_ready) mem[wr_sel][i_madd_wraddr] <= i_madd_data;
  end

  // Both read paths sample the RAM with non-blocking reads, so a same-cycle
  // write to the read address returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        rd_pipe[i] <= '0;
        dr_data[i] <= '0;
      end
      fp_pipe <= '0;
      dr_vld  <= '0;
      dr_last <= '0;
    end else begin
      rd_pipe[0] <= mem[wr_sel][i_madd_rdaddr];
      fp_pipe[0] <= i_first_pass;
      dr_data[0] <= mem[!wr_sel][rd_cnt];
      dr_vld[0]  <= issue;
      dr_last[0] <= issue && (rd_cnt == '1);
      for (int i = 1; i < D; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
        fp_pipe[i] <= fp_pipe[i-1];
        dr_data[i] <= dr_data[i-1];
        dr_vld[i]  <= dr_vld[i-1];
        dr_last[i] <= dr_last[i-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < D; i++) inflight = inflight + FW'(dr_vld[i]);
  end

  // A slot vacated by this cycle's pop counts as free; without it the stream
  // bubbles once the pipeline is full.
  assign credit_ok = ({1'b0, free_slots} + EW'(pop)) > EW'(inflight);

  dp_psum_skid_fifo #(
    .WIDTH (DW + 1),
    .DEPTH (FDEP)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (dr_vld[D-1]),
    .push_data  ({dr_last[D-1], dr_data[D-1]}),
    .out_ready  (i_out_ready),
    .out_valid  (o_out_valid),
    .out_data   (fifo_out),
    .free_slots (free_slots)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DP_PSUM_IDLE;
      rd_cnt       <= '0;
      wr_sel       <= 1'b0;
      swap_pending <= 1'b0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state        <= state_d;
      rd_cnt       <= rd_cnt_d;
      wr_sel       <= wr_sel_d;
      swap_pending <= swap_pending_d;
      err_q        <= err_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d        = state;
    rd_cnt_d       = rd_cnt;
    wr_sel_d       = wr_sel;
    swap_pending_d = swap_pending;
    err_d          = err_q;
    done_d         = 1'b0;
    issue          = 1'b0;
    if (i_madd_we && !o_madd_ready) err_d = 1'b1;
    case (state)
      DP_PSUM_IDLE: begin
        if (i_swap || swap_pending) begin
          wr_sel_d       = !wr_sel;
          rd_cnt_d       = '0;
          swap_pending_d = 1'b0;
          state_d        = DP_PSUM_DRAIN;
        end
      end
      DP_PSUM_DRAIN: begin
        issue = credit_ok;
        if (issue) begin
          rd_cnt_d = rd_cnt + 1'b1;
          if (rd_cnt == '1) state_d = DP_PSUM_FLUSH;
        end
        if (i_swap) begin
          if (swap_pending) err_d = 1'b1;
          else              swap_pending_d = 1'b1;
        end
      end
      DP_PSUM_FLUSH: begin
        if (last_accept) begin
          done_d = 1'b1;
          // A pending swap starts the next drain on the same edge that ends this one.
          if (swap_pending || i_swap) begin
            if (swap_pending && i_swap) err_d = 1'b1;
            wr_sel_d       = !wr_sel;
            rd_cnt_d       = '0;
            swap_pending_d = 1'b0;
            state_d        = DP_PSUM_DRAIN;
          end else begin
            state_d = DP_PSUM_IDLE;
          end
        end else if (i_swap) begin
          if (swap_pending) err_d = 1'b1;
          else              swap_pending_d = 1'b1;
        end
      end
      default: state_d = DP_PSUM_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dp_psum_pp_buffer.sv
// Directed bench for dp_psum_pp_buffer with a 16-entry (AW=4), delay-2 build.
module tb_dp_psum_pp_buffer;

  localparam int AW = 4;
  localparam int DW = 48;

  logic          clk;
  logic          rst;
  logic          i_madd_we;
  logic [AW-1:0] i_madd_wraddr;
  logic [DW-1:0] i_madd_data;
  logic [AW-1:0] i_madd_rdaddr;
  logic          i_first_pass;
  logic [DW-1:0] o_madd_data;
  logic          i_swap;
  logic          o_madd_ready;
  logic          o_out_valid;
  logic [DW-1:0] o_out_data;
  logic          o_out_last;
  logic          i_out_ready;
  logic          o_drain_done;
  logic          o_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] got_data [16];
  logic          got_last [16];
  int            nb;
  int            first_cyc;
  int            bubbles;
  int            unstable;
  bit            done_ok;

  dp_psum_pp_buffer #(
    .COE_WIDTH         (8),
    .ADDR_WIDTH        (2),
    .LOG_NUM_BANK      (2),
    .NUM_POLY          (3),
    .COMMON_BRAM_DELAY (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_madd_we     (i_madd_we),
    .i_madd_wraddr (i_madd_wraddr),
    .i_madd_data   (i_madd_data),
    .i_madd_rdaddr (i_madd_rdaddr),
    .i_first_pass  (i_first_pass),
    .o_madd_data   (o_madd_data),
    .i_swap        (i_swap),
    .o_madd_ready  (o_madd_ready),
    .o_out_valid   (o_out_valid),
    .o_out_data    (o_out_data),
    .o_out_last    (o_out_last),
    .i_out_ready   (i_out_ready),
    .o_drain_done  (o_drain_done),
    .o_err         (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int base);
    for (int a = 0; a < 16; a++) begin
      i_madd_we     = 1'b1;
      i_madd_wraddr = AW'(a);
      i_madd_data   = DW'(base + a);
      tick();
    end
    i_madd_we = 1'b0;
  endtask

  task automatic pulse_swap();
    i_swap = 1'b1;
    tick();
    i_swap = 1'b0;
  endtask

  // Records accepted beats; stall=1 drives ready with the repeating 1,0,0,1 pattern.
  task automatic drain_collect(input bit stall, input int max_beats);
    bit            seen;
    bit            prev_stall;
    bit            rdy;
    logic [DW-1:0] prev_data;
    nb = 0; first_cyc = -1; bubbles = 0; unstable = 0; done_ok = 1'b0;
    seen = 1'b0; prev_stall = 1'b0; prev_data = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      rdy = ((cyc % 4) == 0 || (cyc % 4) == 3) ? 1'b1 : !stall;
      i_out_ready = rdy;
      if (prev_stall && (o_out_valid !== 1'b1 || o_out_data !== prev_data)) unstable++;
      if (o_out_valid === 1'b1 && !seen) begin
        seen = 1'b1;
        first_cyc = cyc;
      end
      if (seen && o_out_valid !== 1'b1) bubbles++;
      prev_stall = (o_out_valid === 1'b1) && !rdy;
      prev_data  = o_out_data;
      if (o_out_valid === 1'b1 && rdy) begin
        if (nb < 16) begin
          got_data[nb] = o_out_data;
          got_last[nb] = o_out_last;
        end
        nb++;
        if (o_out_last === 1'b1) begin
          tick();
          done_ok = (o_drain_done === 1'b1);
          break;
        end
        if (nb == max_beats) break;
      end
      tick();
    end
    i_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (o_madd_data !== '0) begin errors++; $display("FAIL reset_madd_data: got %0h expected 0", o_madd_data); end
    checks++; if (o_madd_ready !== 1'b1) begin errors++; $display("FAIL reset_madd_ready: got %0b expected 1", o_madd_ready); end
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", o_out_valid); end
    checks++; if (o_out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0h expected 0", o_out_data); end
    checks++; if (o_out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %0b expected 0", o_out_last); end
    checks++; if (o_drain_done !== 1'b0) begin errors++; $display("FAIL reset_drain_done: got %0b expected 0", o_drain_done); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", o_err); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_madd_read();
    i_madd_we = 1'b1; i_madd_wraddr = 4'd5; i_madd_data = 48'h11;
    i_madd_rdaddr = 4'd5; i_first_pass = 1'b1;
    tick();
    i_madd_we = 1'b0;
    tick();
    checks++; if (o_madd_data !== 48'h0) begin errors++; $display("FAIL first_pass_zero: got %0h expected 0", o_madd_data); end
    i_first_pass = 1'b0;
    tick();
    checks++; if (o_madd_data !== 48'h0) begin errors++; $display("FAIL read_latency_early: got %0h expected 0", o_madd_data); end
    tick();
    checks++; if (o_madd_data !== 48'h11) begin errors++; $display("FAIL read_latency_2: got %0h expected 11", o_madd_data); end
    i_first_pass = 1'b1;
    tick();
    checks++; if (o_madd_data !== 48'h11) begin errors++; $display("FAIL first_pass_delay: got %0h expected 11", o_madd_data); end
    tick();
    checks++; if (o_madd_data !== 48'h0) begin errors++; $display("FAIL first_pass_applied: got %0h expected 0", o_madd_data); end
  endtask

  task automatic test_read_first();
    i_madd_we = 1'b1; i_madd_wraddr = 4'd3; i_madd_data = 48'h07;
    i_madd_rdaddr = 4'd0; i_first_pass = 1'b1;
    tick();
    i_madd_data = 48'h22; i_madd_rdaddr = 4'd3; i_first_pass = 1'b0;
    tick();
    i_madd_we = 1'b0;
    tick();
    checks++; if (o_madd_data !== 48'h07) begin errors++; $display("FAIL read_first_old: got %0h expected 7", o_madd_data); end
    tick();
    checks++; if (o_madd_data !== 48'h22) begin errors++; $display("FAIL read_after_write: got %0h expected 22", o_madd_data); end
  endtask

  task automatic test_drain();
    logic [DW-1:0] exp;
    fill(1);
    pulse_swap();
    drain_collect(1'b0, 16);
    checks++; if (nb !== 16) begin errors++; $display("FAIL drain_beats: got %0d expected 16", nb); end
    checks++; if (first_cyc !== 3) begin errors++; $display("FAIL drain_latency: got %0d expected 3", first_cyc); end
    checks++; if (bubbles !== 0) begin errors++; $display("FAIL drain_bubbles: got %0d expected 0", bubbles); end
    for (int i = 0; i < 16; i++) begin
      exp = DW'(i + 1);
      checks++; if (got_data[i] !== exp) begin errors++; $display("FAIL drain_data[%0d]: got %0h expected %0h", i, got_data[i], exp); end
      checks++; if (got_last[i] !== (i == 15)) begin errors++; $display("FAIL drain_last[%0d]: got %0b expected %0b", i, got_last[i], (i == 15)); end
    end
    checks++; if (done_ok !== 1'b1) begin errors++; $display("FAIL drain_done_pulse: got %0b expected 1", done_ok); end
    tick();
    checks++; if (o_drain_done !== 1'b0) begin errors++; $display("FAIL drain_done_width: got %0b expected 0", o_drain_done); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] exp;
    fill(1);
    pulse_swap();
    drain_collect(1'b1, 16);
    checks++; if (nb !== 16) begin errors++; $display("FAIL stall_beats: got %0d expected 16", nb); end
    checks++; if (unstable !== 0) begin errors++; $display("FAIL stall_hold: got %0d unstable cycles expected 0", unstable); end
    for (int i = 0; i < 16; i++) begin
      exp = DW'(i + 1);
      checks++; if (got_data[i] !== exp) begin errors++; $display("FAIL stall_data[%0d]: got %0h expected %0h", i, got_data[i], exp); end
    end
    checks++; if (got_last[15] !== 1'b1) begin errors++; $display("FAIL stall_last: got %0b expected 1", got_last[15]); end
    checks++; if (done_ok !== 1'b1) begin errors++; $display("FAIL stall_done: got %0b expected 1", done_ok); end
  endtask

  task automatic test_swap_during_drain();
    int idx;
    fill(64);
    pulse_swap();
    i_out_ready = 1'b1;
    repeat (5) tick();
    pulse_swap();
    checks++; if (o_madd_ready !== 1'b0) begin errors++; $display("FAIL pend_ready_low: got %0b expected 0", o_madd_ready); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL pend_err_clear: got %0b expected 0", o_err); end
    i_madd_we = 1'b1; i_madd_wraddr = 4'd0; i_madd_data = 48'hAA;
    tick();
    i_madd_we = 1'b0;
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL dropped_write_err: got %0b expected 1", o_err); end
    drain_collect(1'b0, 16);
    idx = (nb > 0 && nb <= 16) ? nb - 1 : 0;
    checks++; if (got_data[idx] !== 48'h4F) begin errors++; $display("FAIL pend_last_data: got %0h expected 4f", got_data[idx]); end
    checks++; if (done_ok !== 1'b1) begin errors++; $display("FAIL pend_done: got %0b expected 1", done_ok); end
    checks++; if (o_madd_ready !== 1'b1) begin errors++; $display("FAIL pend_ready_back: got %0b expected 1", o_madd_ready); end
    drain_collect(1'b0, 16);
    checks++; if (nb !== 16) begin errors++; $display("FAIL pend_drain2_beats: got %0d expected 16", nb); end
    checks++; if (first_cyc !== 3) begin errors++; $display("FAIL pend_drain2_latency: got %0d expected 3", first_cyc); end
    checks++; if (got_data[0] !== 48'h1) begin errors++; $display("FAIL dropped_write_data: got %0h expected 1", got_data[0]); end
    checks++; if (got_data[15] !== 48'h10) begin errors++; $display("FAIL pend_drain2_last: got %0h expected 10", got_data[15]); end
    checks++; if (done_ok !== 1'b1) begin errors++; $display("FAIL pend_drain2_done: got %0b expected 1", done_ok); end
  endtask

  task automatic test_reset_mid_drain();
    int dones;
    int valids;
    pulse_swap();
    drain_collect(1'b0, 8);
    checks++; if (got_data[7] !== 48'h47) begin errors++; $display("FAIL abort_beat8: got %0h expected 47", got_data[7]); end
    rst = 1'b1;
    tick();
    checks++; if (o_out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %0b expected 0", o_out_valid); end
    checks++; if (o_out_data !== '0) begin errors++; $display("FAIL abort_data: got %0h expected 0", o_out_data); end
    checks++; if (o_out_last !== 1'b0) begin errors++; $display("FAIL abort_last: got %0b expected 0", o_out_last); end
    checks++; if (o_madd_data !== '0) begin errors++; $display("FAIL abort_madd_data: got %0h expected 0", o_madd_data); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL abort_err: got %0b expected 0", o_err); end
    checks++; if (o_madd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %0b expected 1", o_madd_ready); end
    rst = 1'b0;
    dones = 0; valids = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_drain_done === 1'b1) dones++;
      if (o_out_valid === 1'b1) valids++;
      tick();
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
    checks++; if (valids !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d expected 0", valids); end
    pulse_swap();
    drain_collect(1'b0, 16);
    checks++; if (nb !== 16) begin errors++; $display("FAIL restart_beats: got %0d expected 16", nb); end
    checks++; if (got_data[0] !== 48'h40) begin errors++; $display("FAIL restart_first: got %0h expected 40", got_data[0]); end
    checks++; if (got_data[15] !== 48'h4F) begin errors++; $display("FAIL restart_last: got %0h expected 4f", got_data[15]); end
    checks++; if (done_ok !== 1'b1) begin errors++; $display("FAIL restart_done: got %0b expected 1", done_ok); end
  endtask

  task automatic test_double_swap();
    int dones;
    i_out_ready = 1'b1;
    i_swap = 1'b1;
    tick();
    tick();
    checks++; if (o_madd_ready !== 1'b0) begin errors++; $display("FAIL dswap_ready: got %0b expected 0", o_madd_ready); end
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL dswap_err_before: got %0b expected 0", o_err); end
    tick();
    i_swap = 1'b0;
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL dswap_err: got %0b expected 1", o_err); end
    dones = 0;
    for (int i = 0; i < 300 && dones < 2; i++) begin
      tick();
      if (o_drain_done === 1'b1) dones++;
    end
    checks++; if (dones !== 2) begin errors++; $display("FAIL dswap_drains: got %0d expected 2", dones); end
  endtask

  initial begin
    rst = 1'b1; i_madd_we = 1'b0; i_madd_wraddr = '0; i_madd_data = '0;
    i_madd_rdaddr = '0; i_first_pass = 1'b0; i_swap = 1'b0; i_out_ready = 1'b1;
    test_reset();
    test_madd_read();
    test_read_first();
    test_drain();
    test_stall();
    test_swap_during_drain();
    test_reset_mid_drain();
    test_double_swap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
